voice_alloc: RTL and testbench
==============================

Name: voice_alloc

Overview:
- Parametrised polyphonic voice allocator; successor to the single-note GATE/last-note register pair.
- Sits between midi_in (message decode) and per-voice note_pitch2dds / adsr32 / vca8 chains.
- Maps each NOTE_ON/NOTE_OFF event to one of VOICES voice slots using LRU allocation with oldest-voice stealing.
- Outputs per-voice gate, note, velocity and a retrigger pulse.

Parameters:
- VOICES, 4, number of voice slots (2..16).
- AGE_W, 2, width of per-voice age rank; must equal clog2(VOICES).

Ports:
- clk  in  1  system clock (clk50PLL domain).
- rst  in  1  reset, asynchronous, active-high.
- note_on  in  1  one-cycle strobe: CH_MESSAGE==4'b1001.
- note_off  in  1  one-cycle strobe: CH_MESSAGE==4'b1000.
- note  in  7  MIDI note number; valid with either strobe.
- velocity  in  7  MIDI velocity; valid with note_on.
- sustain  in  1  sustain pedal level, 1 = held. Present only with VOICE_ALLOC_SUSTAIN_EN.
- gate  out  VOICES  per-voice gate, level.
- voice_note  out  VOICES*7  note of voice i at [7i+6:7i].
- voice_vel  out  VOICES*7  velocity of voice i at [7i+6:7i].
- trig  out  VOICES  one-cycle pulse when voice i is (re)assigned.
- all_busy  out  1  all gates high.

Behaviour:
- Reset (async, any time, including mid-event):
  - gate=0, voice_note=0, voice_vel=0, trig=0, all_busy=0.
  - Per-voice age[i]=i, so ages always form a permutation of 0..VOICES-1.
  - Any event in flight is dropped.
- Outputs are registered. An event strobed at cycle N is visible at N+1. trig is high only at N+1.
- Velocity-zero note_on is treated exactly as note_off.
- If note_on and note_off are asserted together, note_on is processed and note_off is ignored.
- note_on(n, v), with v != 0, picks the target voice by priority:
  1. A gated voice whose voice_note==n (retrigger). If several match, the lowest index.
  2. Otherwise, the non-gated voice with the highest age (LRU free voice).
  3. Otherwise (all busy), the voice with age==VOICES-1 (steal oldest).
- On the target voice t:
  - gate[t]=1, voice_note[t]=n, voice_vel[t]=v, trig[t]=1 for one cycle.
  - Age update: every voice j with age[j]<age[t] increments; age[t]=0. Other voices are unchanged.
  - On a steal or retrigger, gate[t] stays 1 with no low cycle; trig marks the restart.
- note_off(n):
  - Every gated voice with voice_note==n gets gate=0.
  - voice_note and voice_vel are held, so the release tail keeps its pitch.
  - Ages are unchanged. If no voice matches, nothing happens.
- all_busy is registered: the AND of the next gate vector.
- Selection is combinational over VOICES slots in one cycle. There is no busy/back-pressure; a strobe on every cycle must be accepted.

Optional Feature:
- Macro: VOICE_ALLOC_SUSTAIN_EN.
- Defined:
  - The sustain port exists, with a per-voice held flag (reset 0).
  - note_off matching a gated voice while sustain=1 sets held[i]=1 and keeps gate[i]=1.
  - On a sustain 1->0 edge, detected from a registered copy, every held voice drops its gate in the next cycle and held clears.
  - A note_on retriggering a held voice clears its held flag.
  - Held voices count as gated for allocation and stealing.
- Undefined: no sustain port, no held state; note_off acts immediately.

Test Plan:
- Reset, VOICES=4; note_on 60/100 -> next cycle gate=4'b1000, voice_note[3]=60, voice_vel[3]=100, trig=4'b1000.
- note_on 62, 64, 65 on consecutive cycles -> voices 2, 1, 0 assigned in turn; gate=4'b1111; all_busy=1.
- Then note_on 67/90 -> steal voice 3: gate[3] stays 1, voice_note[3]=67, trig=4'b1000; ages v3=0, v0=1, v1=2, v2=3.
- note_off 62 -> gate=4'b1011 next cycle, voice_note[2] still 62. Then note_on 64/20 -> retrigger voice 1: trig=4'b0010, voice_vel[1]=20, no new voice used. Then note_on 64/0 -> gate[1]=0.
- Assert rst asynchronously between clock edges with voices active -> gate=0 and trig=0 immediately. Next note_on 70 lands on voice 3.
- SUSTAIN_EN: sustain=1, note_on 60 then note_off 60 -> gate[3] stays 1. Drop sustain -> gate[3]=0 two cycles after the edge is sampled.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: LRU voice assignment with oldest-voice stealing.
// Optional sustain pedal support when VOICE_ALLOC_SUSTAIN_EN is defined.
module voice_alloc #(
  parameter int VOICES = 4,
  parameter int AGE_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  note_on,
  input  logic                  note_off,
  input  logic [6:0]            note,
  input  logic [6:0]            velocity,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                  sustain,
`endif
  output logic [VOICES-1:0]     gate,
  output logic [VOICES*7-1:0]   voice_note,
  output logic [VOICES*7-1:0]   voice_vel,
  output logic [VOICES-1:0]     trig,
  output logic                  all_busy
);

  logic [VOICES-1:0][6:0]       note_r, note_n, vel_r, vel_n;
  logic [VOICES-1:0][AGE_W-1:0] age_r, age_n;
  logic [VOICES-1:0]            gate_r, gate_n, trig_r, trig_n, match;
  logic                         busy_r;
  logic [AGE_W-1:0]             tgt, best;
  logic                         hit, found;
  logic                         on_ev, off_ev;

  // Velocity-zero note_on is a note_off; note_on wins over a simultaneous note_off.
  assign on_ev  = note_on && (velocity != 7'd0);
  assign off_ev = note_on ? (velocity == 7'd0) : note_off;

  for (genvar i = 0; i < VOICES; i++) begin : g_match
    assign match[i] = gate_r[i] && (note_r[i] == note);
  end

`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic [VOICES-1:0] held_r, held_n;
  logic              sus_q, sus_qq, sus_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sus_q  <= 1'b0;
      sus_qq <= 1'b0;
      held_r <= '0;
    end else begin
      sus_q  <= sustain;
      sus_qq <= sus_q;
      held_r <= held_n;
    end
  end

  assign sus_fall = sus_qq & ~sus_q;
`endif

  // Target priority: retrigger (lowest index), then oldest free, then steal oldest.
  always_comb begin
    hit   = 1'b0;
    found = 1'b0;
    best  = '0;
    tgt   = '0;
    for (int i = VOICES - 1; i >= 0; i--)
      if (match[i]) begin
        hit = 1'b1;
        tgt = AGE_W'(i);
      end
    if (!hit) begin
      for (int i = 0; i < VOICES; i++)
        if (!gate_r[i] && (!found || age_r[i] > best)) begin
          found = 1'b1;
          best  = age_r[i];
          tgt   = AGE_W'(i);
        end
      if (!found)
        for (int i = 0; i < VOICES; i++)
          if (age_r[i] == AGE_W'(VOICES - 1)) tgt = AGE_W'(i);
    end
  end

  always_comb begin
    gate_n = gate_r;
    note_n = note_r;
    vel_n  = vel_r;
    age_n  = age_r;
    trig_n = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    held_n = held_r;
    if (sus_fall) begin
      gate_n = gate_r & ~held_r;
      held_n = '0;
    end
`endif
    if (on_ev) begin
      for (int j = 0; j < VOICES; j++)
        if (age_r[j] < age_r[tgt]) age_n[j] = age_r[j] + AGE_W'(1);
      age_n[tgt]  = '0;
      gate_n[tgt] = 1'b1;
      note_n[tgt] = note;
      vel_n[tgt]  = velocity;
      trig_n[tgt] = 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      held_n[tgt] = 1'b0;
`endif
    end else if (off_ev) begin
      for (int i = 0; i < VOICES; i++)
        if (match[i]) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
          if (sustain) held_n[i] = 1'b1;
          else begin
            gate_n[i] = 1'b0;
            held_n[i] = 1'b0;
          end
`else
          gate_n[i] = 1'b0;
`endif
        end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_r <= '0;
      note_r <= '0;
      vel_r  <= '0;
      trig_r <= '0;
      busy_r <= 1'b0;
      for (int i = 0; i < VOICES; i++) age_r[i] <= AGE_W'(i);
    end else begin
      gate_r <= gate_n;
      note_r <= note_n;
      vel_r  <= vel_n;
      trig_r <= trig_n;
      age_r  <= age_n;
      busy_r <= &gate_n;
    end
  end

  assign gate       = gate_r;
  assign voice_note = note_r;
  assign voice_vel  = vel_r;
  assign trig       = trig_r;
  assign all_busy   = busy_r;

endmodule

// File: tb/tb_voice_alloc.sv
// Scoreboard bench for voice_alloc: LRU-list reference model, directed plan plus random events.
module tb_voice_alloc;
  localparam int V  = 4;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           note_on, note_off, sustain;
  logic [6:0]     note, velocity;
  logic [V-1:0]   gate, trig;
  logic [V*7-1:0] voice_note, voice_vel;
  logic           all_busy;

  voice_alloc #(.VOICES(V), .AGE_W(AW)) dut (
    .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
    .note(note), .velocity(velocity),
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .sustain(sustain),
`endif
    .gate(gate), .voice_note(voice_note), .voice_vel(voice_vel),
    .trig(trig), .all_busy(all_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [V-1:0]   gate;
    logic [V*7-1:0] vn;
    logic [V*7-1:0] vv;
    logic [V-1:0]   trig;
    logic           busy;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: lru[k] is the voice whose age is k (front = most recent).
  logic       m_gate[V];
  logic [6:0] m_note[V], m_vel[V];
  int         lru[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    lru.delete();
    for (int i = 0; i < V; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = '0;
      m_vel[i]  = '0;
      lru.push_back(i);
    end
  endtask

  task automatic model_step(input logic on, input logic off, input logic [6:0] n,
                            input logic [6:0] v, output exp_t e);
    int t, pos;
    e = '0;
    if (on && v != 0) begin
      t = -1;
      for (int i = 0; i < V; i++)
        if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
      for (int k = V - 1; k >= 0; k--)
        if (t < 0 && !m_gate[lru[k]]) t = lru[k];
      if (t < 0) t = lru[V-1];
      pos = 0;
      for (int k = 0; k < V; k++) if (lru[k] == t) pos = k;
      lru.delete(pos);
      lru.push_front(t);
      m_gate[t] = 1'b1;
      m_note[t] = n;
      m_vel[t]  = v;
      e.trig[t] = 1'b1;
    end else if (on || off) begin
      for (int i = 0; i < V; i++)
        if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
    end
    e.busy = 1'b1;
    for (int i = 0; i < V; i++) begin
      e.gate[i]      = m_gate[i];
      e.vn[7*i +: 7] = m_note[i];
      e.vv[7*i +: 7] = m_vel[i];
      if (!m_gate[i]) e.busy = 1'b0;
    end
  endtask

  task automatic issue(input logic on, input logic off, input logic [6:0] n, input logic [6:0] v);
    exp_t e;
    @(negedge clk);
    note_on  = on;
    note_off = off;
    note     = n;
    velocity = v;
    model_step(on, off, n, v, e);
    expq.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every registered update is compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && expq.size() > 0) begin
        e = expq.pop_front();
        check("gate", 64'(gate), 64'(e.gate));
        check("voice_note", 64'(voice_note), 64'(e.vn));
        check("voice_vel", 64'(voice_vel), 64'(e.vv));
        check("trig", 64'(trig), 64'(e.trig));
        check("all_busy", 64'(all_busy), 64'(e.busy));
      end
    end
  end

  initial begin
    logic on, off;
    logic [6:0] n, v;
    rst = 1'b1; note_on = 1'b0; note_off = 1'b0; sustain = 1'b0;
    note = '0; velocity = '0;
    model_reset();
    #1;
    check("rst_gate", 64'(gate), 64'd0);
    check("rst_note", 64'(voice_note), 64'd0);
    check("rst_vel", 64'(voice_vel), 64'd0);
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_busy", 64'(all_busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(1, 0, 7'd60, 7'd100);
    after_edge();
    check("tp_first_gate", 64'(gate), 64'b1000);
    check("tp_first_trig", 64'(trig), 64'b1000);
    check("tp_first_note", 64'(voice_note[27:21]), 64'd60);
    check("tp_first_vel", 64'(voice_vel[27:21]), 64'd100);
    issue(1, 0, 7'd62, 7'd80);
    after_edge();
    check("tp_v2_trig", 64'(trig), 64'b0100);
    issue(1, 0, 7'd64, 7'd80);
    after_edge();
    check("tp_v1_trig", 64'(trig), 64'b0010);
    issue(1, 0, 7'd65, 7'd80);
    after_edge();
    check("tp_full_gate", 64'(gate), 64'b1111);
    check("tp_full_busy", 64'(all_busy), 64'd1);
    issue(1, 0, 7'd67, 7'd90);
    after_edge();
    check("tp_steal_trig", 64'(trig), 64'b1000);
    check("tp_steal_gate", 64'(gate), 64'b1111);
    check("tp_steal_note", 64'(voice_note[27:21]), 64'd67);
    issue(0, 1, 7'd62, 7'd0);
    after_edge();
    check("tp_off_gate", 64'(gate), 64'b1011);
    check("tp_off_hold", 64'(voice_note[20:14]), 64'd62);
    issue(1, 0, 7'd64, 7'd20);
    after_edge();
    check("tp_retrig_trig", 64'(trig), 64'b0010);
    check("tp_retrig_vel", 64'(voice_vel[13:7]), 64'd20);
    check("tp_retrig_gate", 64'(gate), 64'b1011);
    issue(1, 0, 7'd64, 7'd0);
    after_edge();
    check("tp_vel0_gate", 64'(gate), 64'b1001);
    issue(1, 1, 7'd61, 7'd33);
    issue(0, 0, 7'd0, 7'd0);

    // Async reset between edges with voices active.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_gate", 64'(gate), 64'd0);
    check("arst_trig", 64'(trig), 64'd0);
    check("arst_busy", 64'(all_busy), 64'd0);
    expq.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(1, 0, 7'd70, 7'd50);
    after_edge();
    check("arst_next_trig", 64'(trig), 64'b1000);

    for (int c = 0; c < 600; c++) begin
      on  = ($urandom_range(0, 2) == 0);
      off = ($urandom_range(0, 2) == 0);
      n   = 7'(60 + $urandom_range(0, 7));
      v   = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      issue(on, off, n, v);
    end
    issue(0, 0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
